// File: rtl/montgomery_exp_ctrl.sv
// Left-to-right square-and-multiply controller driving one Montgomery multiplier.
// Optional macro MEXP_LEADZERO_SKIP_EN: start at the exponent's MSB set instead of bit EXP_WIDTH-1.
module montgomery_exp_ctrl #(
    parameter int WIDTH     = 1024,
    parameter int EXP_WIDTH = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [WIDTH-1:0]     in_rmodm,
    input  logic [WIDTH-1:0]     in_r2modm,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy,
    output logic                 mm_start,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    output logic [WIDTH-1:0]     mm_m,
    input  logic [WIDTH:0]       mm_result,
    input  logic                 mm_done,
    output logic [3:0]           state_dbg
);

    // Multiplier handshake: mm_start pulses for one cycle with mm_a/mm_b/mm_m already
    // registered; they hold until mm_done, which is only honoured in a *_W state.
    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_PRE    = 4'd1,
        S_PRE_W  = 4'd2,
        S_SQ     = 4'd3,
        S_SQ_W   = 4'd4,
        S_MUL    = 4'd5,
        S_MUL_W  = 4'd6,
        S_NEXT   = 4'd7,
        S_POST   = 4'd8,
        S_POST_W = 4'd9,
        S_DONE   = 4'd10
    } state_t;

    state_t               state, state_next;
    logic [EXP_WIDTH-1:0] e_q;
    logic [WIDTH-1:0]     xt, xt_d;
    logic [WIDTH-1:0]     acc, acc_d;
    logic [IW-1:0]        idx;
    logic [WIDTH-1:0]     res_lo;
    logic                 unused_mm_msb;

    assign res_lo        = mm_result[WIDTH-1:0];
    assign unused_mm_msb = mm_result[WIDTH];
    assign busy          = (state != S_IDLE);
    assign state_dbg     = state;

`ifdef MEXP_LEADZERO_SKIP_EN
    function automatic logic [IW-1:0] msb_index(input logic [EXP_WIDTH-1:0] v);
        msb_index = '0;
        for (int k = 0; k < EXP_WIDTH; k++) begin
            if (v[k]) msb_index = IW'(k);
        end
    endfunction
`endif

    // Next values of the accumulators, so operands for the following call can be
    // loaded on the same edge that captures the previous result.
    always_comb begin
        acc_d = acc;
        xt_d  = xt;
        if (mm_done && (state == S_SQ_W || state == S_MUL_W || state == S_POST_W))
            acc_d = res_lo;
        if (mm_done && state == S_PRE_W)
            xt_d = res_lo;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (start) state_next = S_PRE;
            S_PRE:    state_next = S_PRE_W;
`ifdef MEXP_LEADZERO_SKIP_EN
            S_PRE_W:  if (mm_done) state_next = (e_q == '0) ? S_POST : S_SQ;
`else
            S_PRE_W:  if (mm_done) state_next = S_SQ;
`endif
            S_SQ:     state_next = S_SQ_W;
            S_SQ_W:   if (mm_done) state_next = e_q[idx] ? S_MUL : S_NEXT;
            S_MUL:    state_next = S_MUL_W;
            S_MUL_W:  if (mm_done) state_next = S_NEXT;
            S_NEXT:   state_next = (idx == '0) ? S_POST : S_SQ;
            S_POST:   state_next = S_POST_W;
            S_POST_W: if (mm_done) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            e_q      <= '0;
            xt       <= '0;
            acc      <= '0;
            idx      <= '0;
            result   <= '0;
            done     <= 1'b0;
            mm_start <= 1'b0;
            mm_a     <= '0;
            mm_b     <= '0;
            mm_m     <= '0;
        end else begin
            state    <= state_next;
            acc      <= acc_d;
            xt       <= xt_d;
            done     <= 1'b0;
            mm_start <= 1'b0;

            unique case (state)
                S_IDLE: if (start) begin
                    e_q  <= in_e;
                    acc  <= in_rmodm;
                    idx  <= IW'(EXP_WIDTH - 1);
                    mm_a <= in_x;
                    mm_b <= in_r2modm;
                    mm_m <= in_m;
                end
`ifdef MEXP_LEADZERO_SKIP_EN
                S_PRE_W: if (mm_done) idx <= msb_index(e_q);
`endif
                S_NEXT: if (idx != '0) idx <= idx - 1'b1;
                S_DONE: begin
                    result <= acc;
                    done   <= 1'b1;
                end
                default: ;
            endcase

            // Entering a call state issues the request with its operands.
            unique case (state_next)
                S_PRE:  mm_start <= 1'b1;
                S_SQ: begin
                    mm_start <= 1'b1;
                    mm_a     <= acc_d;
                    mm_b     <= acc_d;
                end
                S_MUL: begin
                    mm_start <= 1'b1;
                    mm_a     <= acc_d;
                    mm_b     <= xt_d;
                end
                S_POST: begin
                    mm_start <= 1'b1;
                    mm_a     <= acc_d;
                    mm_b     <= WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// Scoreboard bench for montgomery_exp_ctrl with a behavioural random-latency multiplier.
module tb_montgomery_exp_ctrl;

    localparam int W  = 8;
    localparam int EW = 8;
    localparam logic [W-1:0] MOD    = 8'd13;
    localparam logic [W-1:0] RMODM  = 8'd9;
    localparam logic [W-1:0] R2MODM = 8'd3;
    localparam logic [3:0]   ST_SQ_W = 4'd4;

`ifdef MEXP_LEADZERO_SKIP_EN
    localparam int C_E5 = 7, C_E0 = 2, C_E255 = 18, C_E1 = 4;
`else
    localparam int C_E5 = 12, C_E0 = 10, C_E255 = 18, C_E1 = 11;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [W-1:0]  in_x = '0, in_m = '0, in_rmodm = '0, in_r2modm = '0;
    logic [EW-1:0] in_e = '0;
    logic [W-1:0]  result, mm_a, mm_b, mm_m;
    logic          done, busy, mm_start;
    logic [W:0]    mm_result = '0;
    logic          mm_done = 1'b0;
    logic [3:0]    state_dbg;

    montgomery_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .in_x      (in_x),
        .in_e      (in_e),
        .in_m      (in_m),
        .in_rmodm  (in_rmodm),
        .in_r2modm (in_r2modm),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .mm_start  (mm_start),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_m      (mm_m),
        .mm_result (mm_result),
        .mm_done   (mm_done),
        .state_dbg (state_dbg)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    int           exp_calls_q[$];
    int           call_cnt = 0;
    int           call_base = 0;

    // Bit-serial Montgomery reduction: a*b*2^-W mod m.
    function automatic int mont_ref(input int a, input int b, input int m);
        int t;
        t = a * b;
        for (int k = 0; k < W; k++) begin
            if ((t % 2) == 1) t = t + m;
            t = t / 2;
        end
        if (t >= m) t = t - m;
        return t;
    endfunction

    // ---------------- multiplier model ----------------
    initial begin : mm_model
        logic [W-1:0] cap_a, cap_b, cap_m;
        bit pending;
        bit stable;
        int wait_cnt;
        pending = 0;
        stable  = 1;
        wait_cnt = 0;
        cap_a = '0; cap_b = '0; cap_m = '0;
        forever begin
            @(negedge clk);
            mm_done = 1'b0;
            if (!resetn) begin
                pending  = 0;
                call_cnt = 0;
            end else if (pending) begin
                if (mm_start || mm_a !== cap_a || mm_b !== cap_b || mm_m !== cap_m) stable = 0;
                wait_cnt--;
                if (wait_cnt == 0) begin
                    mm_result = {1'($urandom_range(0, 1)), W'(mont_ref(int'(cap_a), int'(cap_b), int'(cap_m)))};
                    mm_done   = 1'b1;
                    pending   = 0;
                    checks++;
                    if (!stable) begin
                        errors++;
                        $display("FAIL mm_operands_stable: a=%0d b=%0d m=%0d start=%0b, required a=%0d b=%0d m=%0d start=0",
                                 mm_a, mm_b, mm_m, mm_start, cap_a, cap_b, MOD);
                    end
                end
            end else if (mm_start) begin
                cap_a    = mm_a;
                cap_b    = mm_b;
                cap_m    = mm_m;
                stable   = (mm_m === MOD);
                wait_cnt = $urandom_range(3, 20);
                pending  = 1;
                call_cnt++;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [W-1:0] exp_r;
        int exp_c;
        int got_c;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                call_base = 0;
            end else if (done) begin
                got_c = call_cnt - call_base;
                call_base = call_cnt;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: result=%0d, required no done pulse", result);
                end else begin
                    exp_r = exp_q.pop_front();
                    exp_c = exp_calls_q.pop_front();
                    if (result !== exp_r) begin
                        errors++;
                        $display("FAIL result: got %0d, required %0d", result, exp_r);
                    end
                    checks++;
                    if (got_c != exp_c) begin
                        errors++;
                        $display("FAIL mm_call_count: got %0d, required %0d", got_c, exp_c);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; start is seen by the DUT on the following posedge.
    task automatic start_op(input logic [W-1:0] x, input logic [EW-1:0] e, input bit push,
                            input logic [W-1:0] exp_r, input int exp_c);
        in_x      = x;
        in_e      = e;
        in_m      = MOD;
        in_rmodm  = RMODM;
        in_r2modm = R2MODM;
        start     = 1'b1;
        if (push) begin
            exp_q.push_back(exp_r);
            exp_calls_q.push_back(exp_c);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %0b, required 1", busy);
        end
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 0;
        for (int n = 0; n < 5000 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout_%s: done not seen, required within 5000 cycles", tag);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({result, done, busy, mm_start, mm_a, mm_b, mm_m} !== '0) begin
            errors++;
            $display("FAIL %s: result=%0d done=%0b busy=%0b mm_start=%0b mm_a=%0d mm_b=%0d mm_m=%0d, required all 0",
                     tag, result, done, busy, mm_start, mm_a, mm_b, mm_m);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        bit hit;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        start_op(8'd2, 8'd5, 1, 8'd6, C_E5);
        wait_done("x2_e5");
        start_op(8'd7, 8'd0, 1, 8'd1, C_E0);
        wait_done("x7_e0");
        start_op(8'd2, 8'd255, 1, 8'd8, C_E255);
        wait_done("x2_e255");

        // Start while busy must be ignored.
        start_op(8'd3, 8'd1, 1, 8'd3, C_E1);
        repeat (4) @(negedge clk);
        start_op(8'd2, 8'd5, 0, '0, 0);
        wait_done("x3_e1_ignore");
        repeat (30) @(negedge clk);
        checks++;
        if (result !== 8'd3) begin
            errors++;
            $display("FAIL result_held: got %0d, required 3", result);
        end

        // Abort in the middle of a squaring.
        start_op(8'd2, 8'd5, 0, '0, 0);
        hit = 0;
        for (int n = 0; n < 2000 && !hit; n++) begin
            @(negedge clk);
            if (state_dbg == ST_SQ_W) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reach_sq_w: state %0d, required %0d", state_dbg, ST_SQ_W);
        end
        resetn = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        start_op(8'd2, 8'd5, 1, 8'd6, C_E5);
        wait_done("after_reset");

        // Back-to-back: new start in the done cycle.
        repeat (2) @(negedge clk);
        start_op(8'd2, 8'd5, 1, 8'd6, C_E5);
        wait_done("b2b_first");
        start_op(8'd3, 8'd1, 1, 8'd3, C_E1);
        wait_done("b2b_second");

        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
